// File: rtl/dw03_ctr_pkg.sv
// Purpose: shared constants and helpers for the dw03 counter/decoder slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dw03_ctr_pkg;

  // Count direction encodings for count_up_dwn
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Width of the one-hot decode for a WIDTH-bit binary value
  function automatic int dec_w(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/dw03_bin2onehot.sv
// Purpose: binary to one-hot decoder, bit[bin] of onehot is set.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module dw03_bin2onehot
  import dw03_ctr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]        bin,
  output logic [dec_w(WIDTH)-1:0] onehot
);

  // Clear all bits, then set the one selected by bin
  always_comb begin
    onehot      = '0;
    onehot[bin] = 1'b1;
  end

endmodule

// File: rtl/dw03_bictr_decode_mod.sv
// Purpose: up/down counter with programmable limit, wrap/saturate, range-checked preset, one-hot decode.
// Latency: count and flags update one cycle after the controlling inputs; carry_out is combinational.
// Backpressure: none; cen gates counting and load overrides everything.
module dw03_bictr_decode_mod
  import dw03_ctr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEC_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [WIDTH-1:0]        data_preset,
  input  logic                    cen,
  input  logic                    count_up_dwn,
  input  logic                    sat_mode,
  input  logic [WIDTH-1:0]        max_val,
  output logic [WIDTH-1:0]        count,
  output logic [dec_w(WIDTH)-1:0] count_dec,
  output logic                    carry_out,
  output logic                    wrap_pulse,
  output logic                    preset_err
);

  localparam int DEC_W = dec_w(WIDTH);

  logic [WIDTH-1:0] next_count;
  logic             wrap_nxt;
  logic             err_nxt;
  logic             up;

  assign up = (count_up_dwn == CNT_UP);

  // Next-state count: load first, then up/down step with wrap or saturate at the limits.
  // A count left above a shrunken max_val is pulled back only by an up step or a load.
  always_comb begin
    next_count = count;
    wrap_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (load) begin
      if (data_preset > max_val) begin
        next_count = max_val;
        err_nxt    = 1'b1;
      end else begin
        next_count = data_preset;
      end
    end else if (cen) begin
      if (up) begin
        if (count < max_val) begin
          next_count = count + WIDTH'(1);
        end else if (sat_mode) begin
          next_count = max_val;
        end else begin
          next_count = '0;
          wrap_nxt   = 1'b1;
        end
      end else begin
        if (count != '0) begin
          next_count = count - WIDTH'(1);
        end else if (sat_mode) begin
          next_count = '0;
        end else begin
          next_count = max_val;
          wrap_nxt   = 1'b1;
        end
      end
    end
  end

  // Terminal-count flag marks reaching a limit, independent of wrap vs saturate
  assign carry_out = cen & ~load & (up ? (count >= max_val) : (count == '0));

  // Count register and single-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      preset_err <= 1'b0;
    end else begin
      count      <= next_count;
      wrap_pulse <= wrap_nxt;
      preset_err <= err_nxt;
    end
  end

  if (DEC_REG != 0) begin : g_dec_reg
    logic [DEC_W-1:0] next_dec;

    dw03_bin2onehot #(.WIDTH(WIDTH)) u_dec (
      .bin    (next_count),
      .onehot (next_dec)
    );

    // Register the decode of next_count so it lines up with count in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_dec <= DEC_W'(1);
      end else begin
        count_dec <= next_dec;
      end
    end
  end else begin : g_dec_comb
    dw03_bin2onehot #(.WIDTH(WIDTH)) u_dec (
      .bin    (count),
      .onehot (count_dec)
    );
  end

endmodule

// File: tb/tb_dw03_bictr_decode_mod.sv
// Purpose: self-checking bench for dw03_bictr_decode_mod, registered and combinational decode side by side.
// Latency: inputs driven 1ns after a rising edge, registered outputs sampled 1ns after the next edge.
// Backpressure: n/a.
module tb_dw03_bictr_decode_mod;

  localparam int W  = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [W-1:0]  data_preset;
  logic          cen;
  logic          count_up_dwn;
  logic          sat_mode;
  logic [W-1:0]  max_val;

  logic [W-1:0]  count_r, count_c;
  logic [DW-1:0] dec_r, dec_c;
  logic          carry_r, carry_c;
  logic          wrap_r, wrap_c;
  logic          err_r, err_c;

  int n_checks;
  int n_errors;

  dw03_bictr_decode_mod #(.WIDTH(W), .DEC_REG(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .load(load), .data_preset(data_preset), .cen(cen),
    .count_up_dwn(count_up_dwn), .sat_mode(sat_mode), .max_val(max_val),
    .count(count_r), .count_dec(dec_r), .carry_out(carry_r),
    .wrap_pulse(wrap_r), .preset_err(err_r)
  );

  dw03_bictr_decode_mod #(.WIDTH(W), .DEC_REG(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .load(load), .data_preset(data_preset), .cen(cen),
    .count_up_dwn(count_up_dwn), .sat_mode(sat_mode), .max_val(max_val),
    .count(count_c), .count_dec(dec_c), .carry_out(carry_c),
    .wrap_pulse(wrap_c), .preset_err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every registered output of both instances against expected values
  task automatic chk_state(input string tag, input int exp_cnt, input logic exp_wrap, input logic exp_err);
    logic [DW-1:0] exp_dec;
    exp_dec = 16'h0001 << exp_cnt;
    chk({tag, " count_r"}, 32'(count_r), 32'(exp_cnt));
    chk({tag, " count_c"}, 32'(count_c), 32'(exp_cnt));
    chk({tag, " dec_r"},   32'(dec_r),   32'(exp_dec));
    chk({tag, " dec_c"},   32'(dec_c),   32'(exp_dec));
    chk({tag, " wrap_r"},  32'(wrap_r),  32'(exp_wrap));
    chk({tag, " wrap_c"},  32'(wrap_c),  32'(exp_wrap));
    chk({tag, " err_r"},   32'(err_r),   32'(exp_err));
    chk({tag, " err_c"},   32'(err_c),   32'(exp_err));
  endtask

  task automatic chk_carry(input string tag, input logic exp_carry);
    chk({tag, " carry_r"}, 32'(carry_r), 32'(exp_carry));
    chk({tag, " carry_c"}, 32'(carry_c), 32'(exp_carry));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input int dp, input logic c, input logic up,
                       input logic sat, input int mv);
    load         = l;
    data_preset  = W'(dp);
    cen          = c;
    count_up_dwn = up;
    sat_mode     = sat;
    max_val      = W'(mv);
  endtask

  int seq2 [7] = '{1, 2, 3, 4, 5, 0, 1};
  int seq3 [4] = '{1, 0, 0, 0};

  initial begin
    int prev;
    int m_cnt, n_cnt;
    logic e_wrap, e_err, e_carry;
    logic r_load, r_cen, r_up, r_sat;
    int r_dp, r_mv;

    n_checks = 0;
    n_errors = 0;

    // Power-on reset
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 0, 15);
    #12;
    chk_state("por", 0, 0, 0);
    rst_n = 1'b1;

    // Test 1: async reset mid-count at 9, no clock edge involved
    drive(1, 9, 0, 1, 0, 15);
    tick();
    chk_state("t1 load9", 9, 0, 0);
    drive(0, 0, 1, 1, 0, 15);
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("t1 async", 0, 0, 0);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0, 15);
    tick();
    chk_state("t1 hold", 0, 0, 0);

    // Test 2: wrap up with max_val=5
    prev = 0;
    drive(0, 0, 1, 1, 0, 5);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk_carry($sformatf("t2 c%0d", i), prev == 5);
      tick();
      chk_state($sformatf("t2 s%0d", i), seq2[i], seq2[i] == 0, 0);
      prev = seq2[i];
    end

    // Test 3: saturate down from 2 with max_val=5
    drive(1, 2, 0, 0, 1, 5);
    tick();
    chk_state("t3 load2", 2, 0, 0);
    prev = 2;
    drive(0, 0, 1, 0, 1, 5);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_carry($sformatf("t3 c%0d", i), prev == 0);
      tick();
      chk_state($sformatf("t3 s%0d", i), seq3[i], 0, 0);
      prev = seq3[i];
    end

    // Test 4: out-of-range preset with cen also high
    drive(1, 13, 1, 1, 0, 10);
    #1;
    chk_carry("t4 load", 0);
    tick();
    chk_state("t4 clamp", 10, 0, 1);
    drive(0, 0, 0, 1, 0, 10);
    tick();
    chk_state("t4 after", 10, 0, 0);

    // Test 5: max_val shrinks below current count of 12
    drive(1, 12, 0, 1, 0, 15);
    tick();
    chk_state("t5 load12a", 12, 0, 0);
    drive(0, 0, 1, 1, 0, 7);
    #1;
    chk_carry("t5 up wrap", 1);
    tick();
    chk_state("t5 up wrap", 0, 1, 0);
    drive(1, 12, 0, 1, 0, 15);
    tick();
    drive(0, 0, 1, 1, 1, 7);
    tick();
    chk_state("t5 up sat", 7, 0, 0);
    drive(1, 12, 0, 1, 0, 15);
    tick();
    drive(0, 0, 1, 0, 0, 7);
    #1;
    chk_carry("t5 down", 0);
    tick();
    chk_state("t5 down", 11, 0, 0);

    // Degenerate max_val=0: wrap every cycle, both directions
    drive(1, 0, 0, 1, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i % 2) == 0, 0, 0);
      #1;
      chk_carry($sformatf("mv0 c%0d", i), 1);
      tick();
      chk_state($sformatf("mv0 s%0d", i), 0, 1, 0);
    end

    // Test 6: random stimulus against a behavioural model
    m_cnt = 0;
    drive(1, 0, 0, 1, 0, 15);
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r_load = ($urandom_range(0, 7) == 0);
      r_cen  = ($urandom_range(0, 3) != 0);
      r_up   = $urandom_range(0, 1) == 1;
      r_sat  = $urandom_range(0, 1) == 1;
      r_dp   = int'($urandom_range(0, 15));
      r_mv   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : m_cnt + int'($urandom_range(0, 15 - m_cnt));
      if ($urandom_range(0, 9) == 0) r_mv = int'($urandom_range(0, 15));
      drive(r_load, r_dp, r_cen, r_up, r_sat, r_mv);

      e_wrap = 0;
      e_err  = 0;
      n_cnt  = m_cnt;
      if (r_load) begin
        n_cnt = (r_dp > r_mv) ? r_mv : r_dp;
        e_err = (r_dp > r_mv);
      end else if (r_cen && r_up) begin
        if (m_cnt < r_mv)  n_cnt = m_cnt + 1;
        else if (r_sat)    n_cnt = r_mv;
        else begin n_cnt = 0; e_wrap = 1; end
      end else if (r_cen) begin
        if (m_cnt > 0)     n_cnt = m_cnt - 1;
        else if (!r_sat) begin n_cnt = r_mv; e_wrap = 1; end
      end
      e_carry = r_cen && !r_load && (r_up ? (m_cnt >= r_mv) : (m_cnt == 0));

      #1;
      chk_carry("t6", e_carry);
      tick();
      chk_state("t6", n_cnt, e_wrap, e_err);
      m_cnt = n_cnt;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
